// File: rtl/whack_pkg.sv
// Shared constants, FSM state type and BCD / seven-segment helpers for the whack-a-mole scorer.
package whack_pkg;

  localparam int unsigned NUM_MOLES_DEFAULT = 9;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low gfedcba codes, dp (bit 7) held off.
  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_DIGIT[0];
      4'd1:    return SEG_DIGIT[1];
      4'd2:    return SEG_DIGIT[2];
      4'd3:    return SEG_DIGIT[3];
      4'd4:    return SEG_DIGIT[4];
      4'd5:    return SEG_DIGIT[5];
      4'd6:    return SEG_DIGIT[6];
      4'd7:    return SEG_DIGIT[7];
      4'd8:    return SEG_DIGIT[8];
      4'd9:    return SEG_DIGIT[9];
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [6:0] bcd_to_bin(input logic [7:0] b);
    return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction

  // Two-digit BCD add of a small increment; clamps at 99 if the tens digit overflows.
  function automatic logic [7:0] bcd_add(input logic [7:0] s, input logic [3:0] inc);
    logic [4:0] ones;
    logic [4:0] tens;
    ones = 5'(s[3:0]) + 5'(inc);
    tens = 5'(s[7:4]);
    if (ones >= 5'd20) begin
      ones = ones - 5'd20;
      tens = tens + 5'd2;
    end else if (ones >= 5'd10) begin
      ones = ones - 5'd10;
      tens = tens + 5'd1;
    end
    if (tens > 5'd9) return 8'h99;
    return {tens[3:0], ones[3:0]};
  endfunction

  // Two-digit BCD decrement with floor at zero.
  function automatic logic [7:0] bcd_dec(input logic [7:0] s);
    if (s == 8'h00) return 8'h00;
    if (s[3:0] == 4'd0) return {s[7:4] - 4'd1, 4'd9};
    return {s[7:4], s[3:0] - 4'd1};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push button: 2-FF synchroniser, stability counter and one-cycle press pulse on accepted rising edge.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic cin,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Counter runs only while the synchronised input disagrees with the accepted level.
  always_ff @(posedge cin) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync2;
        press <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mole_hit_scorer.sv
// Judges debounced button presses against lit moles, keeps a saturating BCD score and drives HEX0/HEX1.
// Optional feature: define MISS_PENALTY_EN to subtract one point per cycle that contains a miss.
module mole_hit_scorer
  import whack_pkg::*;
#(
  parameter int unsigned NUM_MOLES       = NUM_MOLES_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SCORE_MAX       = 99
) (
  input  logic                 cin,
  input  logic                 rst,
  input  logic [NUM_MOLES-1:0] sw_in,
  input  logic [NUM_MOLES-1:0] mole_mask,
  output logic [NUM_MOLES-1:0] mole_clear,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic [7:0]           score_bcd,
  output logic                 game_over,
  output logic [7:0]           hex0,
  output logic [7:0]           hex1
);

  localparam logic [7:0] MAX_BCD = {4'(SCORE_MAX / 10), 4'(SCORE_MAX % 10)};

  state_t               state;
  logic [NUM_MOLES-1:0] press;
  logic [NUM_MOLES-1:0] hits;
  logic [NUM_MOLES-1:0] misses;
  logic [3:0]           hit_cnt;
  logic [7:0]           sum;
  logic [7:0]           score_next;

  for (genvar gi = 0; gi < NUM_MOLES; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .cin  (cin),
      .rst  (rst),
      .raw  (sw_in[gi]),
      .press(press[gi])
    );
  end

  // Hit/miss split and the candidate score for this cycle's press events.
  always_comb begin
    hits    = press & mole_mask;
    misses  = press & ~mole_mask;
    hit_cnt = 4'd0;
    for (int i = 0; i < NUM_MOLES; i++) begin
      hit_cnt = hit_cnt + 4'(hits[i]);
    end
`ifdef MISS_PENALTY_EN
    if (|misses) begin
      if (hit_cnt != 4'd0) sum = bcd_add(score_bcd, hit_cnt - 4'd1);
      else                 sum = bcd_dec(score_bcd);
    end else begin
      sum = bcd_add(score_bcd, hit_cnt);
    end
`else
    sum = bcd_add(score_bcd, hit_cnt);
`endif
    score_next = (bcd_to_bin(sum) > 7'(SCORE_MAX)) ? MAX_BCD : sum;
  end

  // Game FSM with registered pulses, score and segment decode.
  always_ff @(posedge cin) begin
    if (rst) begin
      state      <= IDLE;
      score_bcd  <= 8'h00;
      mole_clear <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      game_over  <= 1'b0;
      hex0       <= seg7(4'd0);
      hex1       <= SEG_BLANK;
    end else begin
      mole_clear <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      hex0       <= seg7(score_bcd[3:0]);
      hex1       <= (score_bcd[7:4] == 4'd0) ? SEG_BLANK : seg7(score_bcd[7:4]);
      case (state)
        IDLE: begin
          if (|mole_mask) state <= PLAY;
        end
        PLAY: begin
          if (|press) begin
            mole_clear <= hits;
            hit_pulse  <= |hits;
            miss_pulse <= |misses;
            score_bcd  <= score_next;
            if (score_next == MAX_BCD) begin
              state     <= DONE;
              game_over <= 1'b1;
            end
          end
        end
        DONE: begin
          game_over <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
